// File: rtl/gf180mcu_fd_sc_mcu9t5v0__decap_seq.sv
// Sequenced decap bank: ramps a thermometer enable up or down one segment every STEP+1 cycles.
// Optional feature macro GF180MCU_DECAP_SEQ_ABORT_EN lets EN reverse a ramp in progress.
`timescale 1ns/1ps

module gf180mcu_fd_sc_mcu9t5v0__decap_seq #(
    parameter int NSEG   = 16,
    parameter int STEP_W = 4
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              EN,
    input  logic [STEP_W-1:0] STEP,
    output logic [NSEG-1:0]   SEG,
    output logic              BUSY,
    output logic              READY
);

`ifdef GF180MCU_DECAP_SEQ_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_OFF,
        S_UP,
        S_ON,
        S_DOWN
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] cnt;
    logic [STEP_W-1:0] step_lat;

    logic              dwell_done;
    logic [NSEG-1:0]   seg_up;
    logic [NSEG-1:0]   seg_dn;

    // One bit added at the low end or removed at the high end keeps SEG a thermometer code.
    assign dwell_done = (cnt == '0);
    assign seg_up     = {SEG[NSEG-2:0], 1'b1};
    assign seg_dn     = {1'b0, SEG[NSEG-1:1]};

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= S_OFF;
            SEG      <= '0;
            BUSY     <= 1'b0;
            READY    <= 1'b0;
            cnt      <= '0;
            step_lat <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    if (EN) begin
                        state    <= S_UP;
                        SEG      <= {{(NSEG-1){1'b0}}, 1'b1};
                        step_lat <= STEP;
                        cnt      <= STEP;
                        BUSY     <= 1'b1;
                    end
                end
                S_UP: begin
                    if (ABORT && !EN) begin
                        state    <= S_DOWN;
                        step_lat <= STEP;
                        cnt      <= STEP;
                    end else if (dwell_done) begin
                        SEG <= seg_up;
                        cnt <= step_lat;
                        // Setting the top segment completes the ramp.
                        if (SEG[NSEG-2]) begin
                            state <= S_ON;
                            BUSY  <= 1'b0;
                            READY <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ON: begin
                    if (!EN) begin
                        state    <= S_DOWN;
                        SEG      <= seg_dn;
                        step_lat <= STEP;
                        cnt      <= STEP;
                        BUSY     <= 1'b1;
                        READY    <= 1'b0;
                    end
                end
                S_DOWN: begin
                    if (ABORT && EN) begin
                        state    <= S_UP;
                        step_lat <= STEP;
                        cnt      <= STEP;
                    end else if (dwell_done) begin
                        SEG <= seg_dn;
                        cnt <= step_lat;
                        // Clearing SEG[0] (only bit left) ends the ramp.
                        if (!SEG[1]) begin
                            state <= S_OFF;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_OFF;
                    SEG   <= '0;
                    BUSY  <= 1'b0;
                    READY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__decap_seq.sv
// Bench for the decap sequencer: directed ramp scenarios plus randomized EN/STEP/reset traffic.
`timescale 1ns/1ps

module tb_gf180mcu_fd_sc_mcu9t5v0__decap_seq;

    localparam int NSEG   = 16;
    localparam int STEP_W = 4;

`ifdef GF180MCU_DECAP_SEQ_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RN  = 1'b0;
    logic              EN  = 1'b0;
    logic [STEP_W-1:0] STEP = '0;
    logic [NSEG-1:0]   SEG;
    logic              BUSY;
    logic              READY;

    int tests = 0;
    int fails = 0;

    // Reference model: number of lit segments, ramp direction, and the cycle of the next change.
    int level = 0;
    int dir   = 0;
    int s     = 0;
    int nxt   = 0;
    int cyc   = 0;

    gf180mcu_fd_sc_mcu9t5v0__decap_seq #(
        .NSEG  (NSEG),
        .STEP_W(STEP_W)
    ) dut (
        .CLK  (CLK),
        .RN   (RN),
        .EN   (EN),
        .STEP (STEP),
        .SEG  (SEG),
        .BUSY (BUSY),
        .READY(READY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [NSEG-1:0] therm(input int n);
        return NSEG'((64'd1 << n) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic dbusy;
        logic dready;
        dbusy  = (dir != 0);
        dready = (level == NSEG);
        check(tag, 32'({SEG, BUSY, READY}), 32'({therm(level), dbusy, dready}));
    endtask

    task automatic model_edge(input logic en_v, input logic [STEP_W-1:0] st);
        if (dir == 0) begin
            if (level == 0 && en_v) begin
                level = 1; dir = 1; s = int'(st); nxt = cyc + s + 1;
            end else if (level == NSEG && !en_v) begin
                level = NSEG - 1; dir = -1; s = int'(st); nxt = cyc + s + 1;
            end
        end else if (ABORT && ((dir == 1 && !en_v) || (dir == -1 && en_v))) begin
            dir = -dir; s = int'(st); nxt = cyc + s + 1;
        end else if (cyc == nxt) begin
            level = level + dir;
            nxt   = cyc + s + 1;
            if (level == 0 || level == NSEG) dir = 0;
        end
    endtask

    task automatic tick(input logic en_v, input logic [STEP_W-1:0] st, input string tag);
        @(negedge CLK);
        EN   = en_v;
        STEP = st;
        @(posedge CLK);
        cyc++;
        if (RN) model_edge(en_v, st);
        #1;
        check_model(tag);
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge arrives.
    task automatic async_reset(input string tag);
        #2;
        RN = 1'b0;
        EN = 1'b0;
        #1;
        level = 0; dir = 0;
        check(tag, 32'({SEG, BUSY, READY}), 32'd0);
        @(negedge CLK);
        RN = 1'b1;
    endtask

    initial begin
        logic             e;
        int               len;
        logic [STEP_W-1:0] st;

        repeat (3) tick(1'b0, 4'd0, "reset_hold");
        @(negedge CLK);
        RN = 1'b1;
        repeat (3) tick(1'b0, 4'd5, "idle_off");

        // STEP=3 ramp up: a new bit every 4 edges, full at edge 60
        tick(1'b1, 4'd3, "up3_start");
        check("up3_e0", 32'(SEG), 32'h0001);
        repeat (4) tick(1'b1, 4'd3, "up3");
        check("up3_e4", 32'(SEG), 32'h0003);
        repeat (56) tick(1'b1, 4'd3, "up3");
        check("up3_e60", 32'({SEG, BUSY, READY}), 32'({16'hFFFF, 1'b0, 1'b1}));
        repeat (5) tick(1'b1, 4'd7, "hold_on");

        // STEP=1 ramp down: empty at edge 30
        tick(1'b0, 4'd1, "dn1_start");
        check("dn1_e0", 32'(SEG), 32'h7FFF);
        repeat (30) tick(1'b0, 4'd1, "dn1");
        check("dn1_e30", 32'({SEG, BUSY, READY}), 32'd0);
        repeat (4) tick(1'b0, 4'd9, "hold_off");

        // STEP=0: one segment per edge
        tick(1'b1, 4'd0, "up0_start");
        repeat (15) tick(1'b1, 4'd0, "up0");
        check("up0_e15", 32'({SEG, BUSY, READY}), 32'({16'hFFFF, 1'b0, 1'b1}));
        tick(1'b0, 4'd0, "dn0_start");
        repeat (15) tick(1'b0, 4'd0, "dn0");
        check("dn0_e15", 32'({SEG, BUSY, READY}), 32'd0);

        // STEP changed mid-ramp is ignored until the next latching edge
        tick(1'b1, 4'd3, "chg_start");
        repeat (59) tick(1'b1, 4'd0, "chg_up");
        check("chg_e59", 32'(SEG), 32'h7FFF);
        tick(1'b1, 4'd0, "chg_up");
        check("chg_e60", 32'({SEG, READY}), 32'({16'hFFFF, 1'b1}));
        tick(1'b0, 4'd0, "chg_dn_start");
        repeat (15) tick(1'b0, 4'd0, "chg_dn");
        check("chg_dn_e15", 32'(SEG), 32'h0000);
        tick(1'b1, 4'd0, "chg_up2_start");
        repeat (15) tick(1'b1, 4'd0, "chg_up2");
        check("chg_up2_e15", 32'({SEG, READY}), 32'({16'hFFFF, 1'b1}));
        tick(1'b0, 4'd0, "chg_dn2_start");
        repeat (15) tick(1'b0, 4'd0, "chg_dn2");

        // EN dropped mid-ramp at SEG=0x000F
        tick(1'b1, 4'd2, "ab_start");
        repeat (9) tick(1'b1, 4'd2, "ab_up");
        check("ab_e9", 32'(SEG), 32'h000F);
        tick(1'b0, 4'd2, "ab_drop");
        check("ab_drop", 32'(SEG), 32'h000F);
        repeat (3) tick(1'b0, 4'd2, "ab_after");
        check("ab_drop_p3", 32'(SEG), ABORT ? 32'h0007 : 32'h001F);
        repeat (100) tick(1'b0, 4'd2, "ab_finish");
        check("ab_off", 32'({SEG, BUSY, READY}), 32'd0);

        // Asynchronous reset mid-ramp at SEG=0x00FF
        tick(1'b1, 4'd0, "rst_up_start");
        repeat (7) tick(1'b1, 4'd0, "rst_up");
        check("rst_pre", 32'(SEG), 32'h00FF);
        async_reset("rst_async");
        tick(1'b1, 4'd0, "rst_restart");
        check("rst_restart_seg", 32'(SEG), 32'h0001);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            e   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            for (int j = 0; j < len; j++) begin
                st = STEP_W'($urandom_range(0, 15));
                tick(e, st, "rand");
            end
            if ($urandom_range(0, 9) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
